// File: rtl/guess_submit_ctrl.sv
// rtl/guess_submit_ctrl.sv - debounced submit button FSM with guess capture; optional SUBMIT_COUNT_EN adds submit_count
module guess_submit_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_submit,
    input  logic [3:0] guess_in,
    output logic       guess_submitted,
    output logic [3:0] guess_q,
    output logic       busy
`ifdef SUBMIT_COUNT_EN
    ,
    output logic [7:0] submit_count
`endif
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        PULSE        = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [19:0] cnt;
    logic [19:0] cnt_next;
    logic        sync1;
    logic        btn_sync;

    // The raw button is asynchronous to clk; two flops before any decision uses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sync1    <= btn_submit;
            btn_sync <= sync1;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_next = DEBOUNCE;
                    cnt_next   = 20'd0;
                end
            end
            DEBOUNCE: begin
                if (!btn_sync) begin
                    state_next = IDLE;
                    cnt_next   = 20'd0;
                end else if (cnt == CNT_LAST) begin
                    state_next = PULSE;
                end else begin
                    cnt_next = cnt + 20'd1;
                end
            end
            PULSE: begin
                state_next = WAIT_RELEASE;
                cnt_next   = 20'd0;
            end
            WAIT_RELEASE: begin
                // Any bounce back high restarts the release window.
                if (btn_sync) begin
                    cnt_next = 20'd0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = 20'd0;
                end else begin
                    cnt_next = cnt + 20'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 20'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= 20'd0;
            guess_submitted <= 1'b0;
            guess_q         <= 4'h0;
            busy            <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            guess_submitted <= (state_next == PULSE);
            busy            <= (state_next != IDLE);
            if (state_next == PULSE && state != PULSE) begin
                guess_q <= guess_in;
            end
        end
    end

`ifdef SUBMIT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            submit_count <= 8'd0;
        end else if (state_next == PULSE && state != PULSE && submit_count != 8'hFF) begin
            submit_count <= submit_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_guess_submit_ctrl.sv
// tb/tb_guess_submit_ctrl.sv - randomized self-checking bench for guess_submit_ctrl against a run-length model
module tb_guess_submit_ctrl;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic       btn_submit;
    logic [3:0] guess_in;
    logic       guess_submitted;
    logic [3:0] guess_q;
    logic       busy;
`ifdef SUBMIT_COUNT_EN
    logic [7:0] submit_count;
`endif

    guess_submit_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .btn_submit      (btn_submit),
        .guess_in        (guess_in),
        .guess_submitted (guess_submitted),
        .guess_q         (guess_q),
        .busy            (busy)
`ifdef SUBMIT_COUNT_EN
        ,
        .submit_count    (submit_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: button seen two edges late; a press is a run of D+1 high samples,
    // a release a run of D low samples, with one dead sample right after the pulse.
    localparam int ARMED = 0, SKIP = 1, REL = 2;
    int   seen_1, seen_2;
    int   phase, run_hi, run_lo;
    logic exp_pulse;
    logic [3:0] exp_q;
    int   exp_cnt;
    int   model_pulses;
    int   dut_pulses;
    int   edge_no;
    int   first_pulse_edge;
    int   busy_edge3;
    int   busy_edge2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        seen_1 = 0; seen_2 = 0;
        phase = ARMED; run_hi = 0; run_lo = 0;
        exp_pulse = 1'b0; exp_q = 4'h0; exp_cnt = 0;
    endtask

    function automatic logic exp_busy();
        return !(phase == ARMED && run_hi == 0);
    endfunction

    task automatic model_step(input logic b_raw, input logic [3:0] g);
        int b;
        b = seen_2;
        seen_2 = seen_1;
        seen_1 = int'(b_raw);
        exp_pulse = 1'b0;
        case (phase)
            ARMED: begin
                if (b != 0) begin
                    run_hi++;
                    if (run_hi == D + 1) begin
                        exp_pulse = 1'b1;
                        exp_q = g;
                        if (exp_cnt < 255) exp_cnt++;
                        model_pulses++;
                        phase = SKIP;
                    end
                end else begin
                    run_hi = 0;
                end
            end
            SKIP: begin
                phase = REL;
                run_lo = 0;
            end
            default: begin
                if (b != 0) run_lo = 0;
                else begin
                    run_lo++;
                    if (run_lo == D) begin
                        phase = ARMED;
                        run_hi = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic compare_outputs();
        check("guess_submitted", 32'(guess_submitted), 32'(exp_pulse));
        check("guess_q", 32'(guess_q), 32'(exp_q));
        check("busy", 32'(busy), 32'(exp_busy()));
`ifdef SUBMIT_COUNT_EN
        check("submit_count", 32'(submit_count), 32'(exp_cnt));
`endif
    endtask

    // One clock: inputs driven away from the edge, model advanced on the edge, outputs checked 1ns later.
    task automatic cycle(input logic b, input logic [3:0] g);
        btn_submit = b;
        guess_in   = g;
        @(posedge clk);
        edge_no++;
        if (rst_n) model_step(b, g);
        else model_reset();
        #1;
        if (guess_submitted === 1'b1) begin
            dut_pulses++;
            if (first_pulse_edge < 0) first_pulse_edge = edge_no;
        end
        if (edge_no == 2) busy_edge2 = int'(busy);
        if (edge_no == 3) busy_edge3 = int'(busy);
        compare_outputs();
    endtask

    task automatic async_reset(input int hold);
        rst_n = 1'b0;
        btn_submit = 1'b0;
        #1;
        check("rst_async_pulse", 32'(guess_submitted), 32'd0);
        check("rst_async_q", 32'(guess_q), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        model_reset();
        for (int i = 0; i < hold; i++) cycle(1'b0, 4'($urandom));
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        btn_submit = 1'b0;
        guess_in = 4'h0;
        model_pulses = 0;
        dut_pulses = 0;
        edge_no = 0;
        first_pulse_edge = -1;
        busy_edge2 = -1;
        busy_edge3 = -1;
        model_reset();
        #2;
        check("reset_pulse", 32'(guess_submitted), 32'd0);
        check("reset_q", 32'(guess_q), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0);
        rst_n = 1'b1;

        // Held press with guess 7: pulse after edge D+3, busy from edge 3.
        edge_no = 0;
        for (int i = 0; i < 100; i++) cycle(1'b1, 4'h7);
        check("latency_edge", 32'(first_pulse_edge), 32'(D + 3));
        check("busy_edge2", 32'(busy_edge2), 32'd0);
        check("busy_edge3", 32'(busy_edge3), 32'd1);
        check("held_one_pulse", 32'(dut_pulses), 32'd1);
        check("captured_7", 32'(guess_q), 32'h7);

        // One-cycle release then press again: still one pulse.
        cycle(1'b0, 4'h1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 4'h2);
        check("short_release", 32'(dut_pulses), 32'd1);

        // Proper release then press: second pulse; guess churns during WAIT_RELEASE.
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'($urandom));
        for (int i = 0; i < 10; i++) cycle(1'b1, 4'hA);
        for (int i = 0; i < 10; i++) cycle(1'b1, 4'($urandom));
        check("second_pulse", 32'(dut_pulses), 32'd2);
        check("q_held_in_wait", 32'(guess_q), 32'hA);

        // Short glitch of D-1 high cycles: no pulse, guess_q unchanged.
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'h3);
        for (int i = 0; i < D - 1; i++) cycle(1'b1, 4'h5);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'h5);
        check("glitch_no_pulse", 32'(dut_pulses), 32'd2);
        check("glitch_q", 32'(guess_q), 32'hA);
        check("glitch_idle", 32'(busy), 32'd0);

        // Reset while in DEBOUNCE aborts the submission.
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'hC);
        check("in_debounce_busy", 32'(busy), 32'd1);
        async_reset(3);
        for (int i = 0; i < 20; i++) cycle(1'b0, 4'hC);
        check("abort_no_pulse", 32'(dut_pulses), 32'd2);

        // Randomized segments with occasional asynchronous reset.
        for (int s = 0; s < 400; s++) begin
            int len;
            logic lvl;
            lvl = s[0];
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(D, 3 * D) : $urandom_range(1, D + 2);
            for (int i = 0; i < len; i++) cycle(lvl, 4'($urandom));
            if ($urandom_range(0, 49) == 0) async_reset($urandom_range(1, 3));
        end

        // Many clean presses; exercises count saturation when present.
        for (int p = 0; p < 262; p++) begin
            for (int i = 0; i < D + 3; i++) cycle(1'b1, 4'(p));
            for (int i = 0; i < D + 3; i++) cycle(1'b0, 4'($urandom));
        end
        check("total_pulses", 32'(dut_pulses), 32'(model_pulses));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
